// File: rtl/puf_eval_ctrl_if.sv
// rtl/puf_eval_ctrl_if.sv - result handshake bundle between the PUF sequencer and its consumer
interface puf_eval_ctrl_if #(
    parameter int CW = 32
);
    logic          resp_valid;
    logic          resp_ready;
    logic [3:0]    resp_data;
    logic [3:0]    resp_unstable;
    logic [CW-1:0] resp_chal;

    modport master (
        output resp_valid,
        output resp_data,
        output resp_unstable,
        output resp_chal,
        input  resp_ready
    );

    modport slave (
        input  resp_valid,
        input  resp_data,
        input  resp_unstable,
        input  resp_chal,
        output resp_ready
    );
endinterface

// File: rtl/puf_eval_ctrl.sv
// rtl/puf_eval_ctrl.sv - arbiter-PUF challenge sequencer with NREP-sample majority vote
module puf_eval_ctrl #(
    parameter int            CW     = 32,
    parameter int            NREP   = 5,
    parameter int            SETTLE = 4,
    parameter logic [CW-1:0] SEED   = 'h1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           mode,
    input  logic [7:0]     num,
    input  logic [CW-1:0]  ext_chal,
    input  logic           seed_load,
    input  logic [CW-1:0]  seed,
    input  logic           abort,
    input  logic [3:0]     puf_resp,
    output logic [CW-1:0]  c_bits,
    output logic           busy,
    puf_eval_ctrl_if.master rsp
);
    localparam int            SW        = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SW-1:0] SET_LAST  = SW'(SETTLE - 1);
    localparam logic [3:0]    REP_LAST  = 4'(NREP - 1);
    localparam logic [3:0]    HALF      = 4'(NREP / 2);
    localparam logic [3:0]    FULL      = 4'(NREP);
    localparam logic [CW-1:0] SEED_INIT = (SEED == '0) ? CW'(1) : SEED;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REARM,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  lfsr;
    logic [CW-1:0]  lfsr_adv;
    logic [CW-1:0]  cur;
    logic           mode_q;
    logic [8:0]     batch;
    logic [SW-1:0]  settle_cnt;
    logic [3:0]     rep_cnt;
    logic [3:0][3:0] cnt;
    logic [3:0][3:0] sum;
    logic [3:0]     vote_data;
    logic [3:0]     vote_unst;
    logic           last_rep;
    logic           accept;

    // Fibonacci LFSR, shift left, feedback taps 31/21/1/0
    function automatic logic [CW-1:0] lfsr_next(input logic [CW-1:0] v);
        return {v[CW-2:0], v[CW-1] ^ v[21] ^ v[1] ^ v[0]};
    endfunction

    assign lfsr_adv = lfsr_next(lfsr);
    assign last_rep = (rep_cnt == REP_LAST);
    assign accept   = (state == S_DONE) && rsp.resp_ready;
    assign busy     = (state != S_IDLE);

    // Vote includes the sample being taken in the current SAMPLE cycle
    always_comb begin
        sum       = '0;
        vote_data = '0;
        vote_unst = '0;
        for (int i = 0; i < 4; i++) begin
            sum[i]       = cnt[i] + {3'b000, puf_resp[i]};
            vote_data[i] = (sum[i] > HALF);
            vote_unst[i] = (sum[i] != 4'd0) && (sum[i] != FULL);
        end
    end

    always_comb begin
        c_bits = '0;
        if (state == S_SETTLE || state == S_SAMPLE || state == S_DONE) begin
            c_bits = cur;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (start) state_nxt = S_REARM;
                S_REARM:  state_nxt = S_SETTLE;
                S_SETTLE: if (settle_cnt == SET_LAST) state_nxt = S_SAMPLE;
                S_SAMPLE: state_nxt = last_rep ? S_DONE : S_REARM;
                S_DONE:   if (rsp.resp_ready) state_nxt = (batch == 9'd1) ? S_IDLE : S_REARM;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr              <= SEED_INIT;
            cur               <= '0;
            mode_q            <= 1'b0;
            batch             <= '0;
            settle_cnt        <= '0;
            rep_cnt           <= '0;
            cnt               <= '0;
            rsp.resp_valid    <= 1'b0;
            rsp.resp_data     <= '0;
            rsp.resp_unstable <= '0;
            rsp.resp_chal     <= '0;
        end else if (abort) begin
            settle_cnt     <= '0;
            rep_cnt        <= '0;
            cnt            <= '0;
            rsp.resp_valid <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (seed_load) begin
                        lfsr <= (seed == '0) ? CW'(1) : seed;
                    end
                    if (start) begin
                        mode_q     <= mode;
                        cur        <= mode ? ext_chal : lfsr;
                        batch      <= mode ? 9'd1 : ((num == 8'd0) ? 9'd256 : {1'b0, num});
                        settle_cnt <= '0;
                        rep_cnt    <= '0;
                        cnt        <= '0;
                    end
                end
                S_REARM: begin
                    settle_cnt <= '0;
                end
                S_SETTLE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
                S_SAMPLE: begin
                    cnt <= sum;
                    if (last_rep) begin
                        rsp.resp_valid    <= 1'b1;
                        rsp.resp_data     <= vote_data;
                        rsp.resp_unstable <= vote_unst;
                        rsp.resp_chal     <= cur;
                    end else begin
                        rep_cnt <= rep_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    if (accept) begin
                        rsp.resp_valid <= 1'b0;
                        batch          <= batch - 1'b1;
                        rep_cnt        <= '0;
                        cnt            <= '0;
                        if (!mode_q) begin
                            lfsr <= lfsr_adv;
                            cur  <= lfsr_adv;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_puf_eval_ctrl.sv
// tb/tb_puf_eval_ctrl.sv - scoreboard bench for puf_eval_ctrl
module tb_puf_eval_ctrl;
    typedef struct packed {
        logic [3:0]  data;
        logic [3:0]  unst;
        logic [31:0] chal;
    } exp_t;

    localparam logic [19:0] STABLE = {5{4'b1010}};
    localparam logic [19:0] NOISY  = {4'b0011, 4'b0010, 4'b0011, 4'b1010, 4'b0011};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [7:0]  num = 8'd0;
    logic [31:0] ext_chal = '0;
    logic        seed_load = 1'b0;
    logic [31:0] seed = '0;
    logic        abort = 1'b0;
    logic [3:0]  puf_resp = '0;
    logic [31:0] c_bits;
    logic        busy;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    puf_eval_ctrl_if #(.CW(32)) rsp_if ();

    puf_eval_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode      (mode),
        .num       (num),
        .ext_chal  (ext_chal),
        .seed_load (seed_load),
        .seed      (seed),
        .abort     (abort),
        .puf_resp  (puf_resp),
        .c_bits    (c_bits),
        .busy      (busy),
        .rsp       (rsp_if.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_if.resp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_valid: got chal %0h want no result", rsp_if.resp_chal);
            end else if (rsp_if.resp_ready === 1'b1) begin
                mon_e = sb.pop_front();
                chk("resp_data", 64'(rsp_if.resp_data), 64'(mon_e.data));
                chk("resp_unstable", 64'(rsp_if.resp_unstable), 64'(mon_e.unst));
                chk("resp_chal", 64'(rsp_if.resp_chal), 64'(mon_e.chal));
            end
        end
    end

    task automatic push_exp(input logic [3:0] d, input logic [3:0] u, input logic [31:0] ch);
        exp_t e;
        e.data = d;
        e.unst = u;
        e.chal = ch;
        sb.push_back(e);
    endtask

    task automatic do_start(input logic m, input logic [7:0] n, input logic [31:0] ch);
        mode = m;
        num = n;
        ext_chal = ch;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic do_seed(input logic [31:0] v);
        seed = v;
        seed_load = 1'b1;
        @(posedge clk); #1;
        seed_load = 1'b0;
    endtask

    task automatic do_accept();
        rsp_if.resp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_if.resp_ready = 1'b0;
    endtask

    // Called 1ns after the edge that enters REARM; runs NREP*(SETTLE+2)=30 cycles
    task automatic eval_seq(input logic [31:0] chal, input logic [19:0] pats);
        int bad_rearm = 0;
        int bad_settle = 0;
        int early = 0;
        for (int n = 0; n < 30; n++) begin
            if (n % 6 == 0) begin
                puf_resp = pats[4*(n/6) +: 4];
                if (c_bits !== 32'h0) bad_rearm++;
            end else if (c_bits !== chal) begin
                bad_settle++;
            end
            if (rsp_if.resp_valid !== 1'b0) early++;
            @(posedge clk); #1;
        end
        chk("c_bits_rearm_zero", 64'(bad_rearm), 64'd0);
        chk("c_bits_settle", 64'(bad_settle), 64'd0);
        chk("no_early_valid", 64'(early), 64'd0);
        chk("valid_at_30", 64'(rsp_if.resp_valid), 64'd1);
        chk("c_bits_done", 64'(c_bits), 64'(chal));
    endtask

    initial begin
        int bad;
        rsp_if.resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_c_bits", 64'(c_bits), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_valid", 64'(rsp_if.resp_valid), 64'd0);
        chk("rst_data", 64'(rsp_if.resp_data), 64'd0);
        chk("rst_unstable", 64'(rsp_if.resp_unstable), 64'd0);
        chk("rst_chal", 64'(rsp_if.resp_chal), 64'd0);

        // external challenge, stable PUF
        push_exp(4'b1010, 4'b0000, 32'hDEADBEEF);
        do_start(1'b1, 8'd0, 32'hDEADBEEF);
        eval_seq(32'hDEADBEEF, STABLE);
        do_accept();
        chk("ext_valid_drop", 64'(rsp_if.resp_valid), 64'd0);
        chk("ext_busy_drop", 64'(busy), 64'd0);

        // noisy PUF: bit0 3/5 ones, bit1 5/5, bit2 0/5, bit3 1/5
        push_exp(4'b0011, 4'b1001, 32'h12345678);
        do_start(1'b1, 8'd0, 32'h12345678);
        eval_seq(32'h12345678, NOISY);
        do_accept();

        // LFSR single run from seed 1 leaves the LFSR at 3
        do_seed(32'h1);
        push_exp(4'b1010, 4'b0000, 32'h1);
        do_start(1'b0, 8'd1, 32'h0);
        eval_seq(32'h1, STABLE);
        do_accept();

        // asynchronous reset mid-SETTLE
        do_start(1'b1, 8'd0, 32'hAAAA5555);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_c_bits", 64'(c_bits), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_valid", 64'(rsp_if.resp_valid), 64'd0);
        chk("arst_data", 64'(rsp_if.resp_data), 64'd0);
        chk("arst_unstable", 64'(rsp_if.resp_unstable), 64'd0);
        chk("arst_chal", 64'(rsp_if.resp_chal), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        push_exp(4'b0011, 4'b1001, 32'h1);
        do_start(1'b0, 8'd1, 32'h0);
        eval_seq(32'h1, NOISY);
        do_accept();
        chk("post_rst_busy", 64'(busy), 64'd0);

        // LFSR batch of 3 with backpressure on the second result
        do_seed(32'h1);
        push_exp(4'b1010, 4'b0000, 32'h1);
        push_exp(4'b1010, 4'b0000, 32'h3);
        push_exp(4'b1010, 4'b0000, 32'h6);
        do_start(1'b0, 8'd3, 32'h0);
        eval_seq(32'h1, STABLE);
        do_accept();
        chk("batch_busy_1", 64'(busy), 64'd1);
        eval_seq(32'h3, STABLE);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (rsp_if.resp_valid !== 1'b1 || rsp_if.resp_chal !== 32'h3 ||
                rsp_if.resp_data !== 4'b1010 || busy !== 1'b1) bad++;
            @(posedge clk); #1;
        end
        chk("backpressure_hold", 64'(bad), 64'd0);
        do_accept();
        eval_seq(32'h6, STABLE);
        do_accept();
        chk("batch_busy_end", 64'(busy), 64'd0);
        chk("batch_valid_end", 64'(rsp_if.resp_valid), 64'd0);

        // zero seed is stored as 1
        do_seed(32'h0);
        push_exp(4'b1010, 4'b0000, 32'h1);
        do_start(1'b0, 8'd1, 32'h0);
        eval_seq(32'h1, STABLE);
        do_accept();

        // abort in SETTLE of rep 3, with start asserted in the same cycle
        puf_resp = 4'b1010;
        do_start(1'b1, 8'd0, 32'hBAD0BAD0);
        repeat (13) @(posedge clk);
        #1;
        abort = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        start = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_c_bits", 64'(c_bits), 64'd0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_if.resp_valid !== 1'b0 || busy !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        chk("abort_quiet", 64'(bad), 64'd0);
        push_exp(4'b1010, 4'b0000, 32'hCAFEF00D);
        do_start(1'b1, 8'd0, 32'hCAFEF00D);
        eval_seq(32'hCAFEF00D, STABLE);
        do_accept();

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
